clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Programmable clock-enable controller for the VGA clock path. It holds the active divide ratio and generates a one-cycle `tick` enable plus a square-wave `newClk`. Divide-ratio changes arrive over a valid/ready handshake and take effect only on a period boundary, so downstream VGA timing logic never sees a runt or stretched period. Everything runs in the single system clock domain; `tick` is the intended enable for pixel-rate logic.

Parameters:
- CNT_W, 16, width of divisor and internal counter
- DEFAULT_DIV, 4, divisor loaded at reset (100 MHz to 25 MHz pixel rate)
- TCNT_W, 16, width of tick_count

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = divider running; 0 = held idle
- cfg_valid  in  1  new divisor offered
- cfg_div  in  CNT_W  requested divisor N (clk cycles per output period)
- cfg_ready  out  1  controller can accept a config
- cfg_err  out  1  one-cycle pulse: offered divisor rejected
- tick  out  1  one-cycle pulse on the last cycle of each period
- newClk  out  1  divided square wave
- active_div  out  CNT_W  divisor currently in force
- busy  out  1  a config is pending (accepted, not yet applied)
- tick_count  out  TCNT_W  ticks since last reset or config apply

Behaviour:
- Reset (synchronous, highest priority):
  - cnt=0, active_div=DEFAULT_DIV
  - tick=0, newClk=0, cfg_err=0, busy=0, cfg_ready=1, tick_count=0
  - pending register cleared; state=IDLE
- States:
  - IDLE: run=0. cnt held at 0, tick=0, newClk=0.
  - RUN: run=1, no pending config.
  - PEND: run=1, config pending.
- IDLE to RUN: on the first cycle with run=1, cnt starts at 0.
- RUN/PEND to IDLE: the cycle after run=0.
  - cnt=0, newClk=0, no tick.
  - Any pending config is applied on entry to IDLE.
- Counter (RUN/PEND):
  - cnt increments by 1 each cycle.
  - At cnt==active_div-1: tick=1 for that cycle, and the next cnt is 0.
- newClk (registered):
  - In every cycle, newClk == (cnt >= active_div>>1), with cnt being the value in that cycle.
  - Low for floor(N/2) cycles, then high for ceil(N/2) cycles; falls on the cycle after tick.
- tick_count: increments (wraps) on each tick; cleared to 0 when a config is applied.
- Config acceptance:
  - A transfer occurs on clk edge with cfg_valid && cfg_ready.
  - cfg_ready = !busy (combinational).
- Validity check:
  - cfg_div < 2 is rejected: cfg_err=1 next cycle, nothing stored, state unchanged, cfg_ready stays 1.
- Accepted in IDLE: active_div=cfg_div next cycle; busy never asserts.
- Accepted in RUN: divisor stored, busy=1, cfg_ready=0, state=PEND.
  - Applied on the wrap after the next tick: the cycle with cnt=0 uses the new active_div.
  - busy clears in that same cycle.
- Accepted in the same cycle as tick (cnt==N-1): applied at that wrap, so the following period uses the new divisor. busy pulses for exactly one cycle.
- Divisor change while run is toggling: the pending config is applied on entry to IDLE.
- Reset mid-PEND discards the pending value; active_div=DEFAULT_DIV.
- Arithmetic:
  - Comparisons are unsigned, CNT_W bits.
  - Max divisor 2^CNT_W-1.
  - cnt never exceeds active_div-1.

Test Plan:
- Reset, run=1, default N=4: tick at cnt 3 every 4 cycles; newClk sequence 0,0,1,1 repeating; tick_count 1,2,3 after 12 cycles.
- Mid-period reconfig: in RUN N=4 at cnt=1, offer cfg_div=6.
  - Response: busy=1, cfg_ready=0; old period completes with tick at cnt=3.
  - Next period is 6 cycles with newClk 0,0,0,1,1,1.
  - busy=0 and tick_count=0 at the wrap.
- Invalid divisor: offer cfg_div=1, then 0. Response: cfg_err pulses one cycle each, active_div stays 4, period unchanged.
- Odd divisor: in IDLE, load 5, set run=1. Response: newClk low 2 cycles, high 3; tick every 5 cycles.
- Boundary and control corners:
  - Config offered at cnt==N-1 (N=4, cfg_div=3): next period is 3 cycles, busy high one cycle.
  - run=0 at cnt=2 with a pending 8: next cycle IDLE, newClk=0, active_div=8.
- Reset while PEND: active_div=4, busy=0, cfg_ready=1, cnt=0.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration channel for clk_div_ctrl.
// valid/ready transfer plus a one-cycle reject pulse back to the master.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider for the VGA pixel path.
// Divisor changes land only on period boundaries (or on entry to idle).
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int TCNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    clk_div_ctrl_if.slave     cfg,
    output logic              tick,
    output logic              newClk,
    output logic [CNT_W-1:0]  active_div,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [CNT_W-1:0]  ONE  = 1;
    localparam logic [TCNT_W-1:0] TONE = 1;
    localparam logic [CNT_W-1:0]  DEF  = CNT_W'(DEFAULT_DIV);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   pend_div, pend_n;
    logic [CNT_W-1:0]   div_n;
    logic [TCNT_W-1:0]  tcnt_n;
    logic               applied, applied_n;
    logic               busy_n, err_n;
    logic               take, ok, wrap;

    assign cfg.cfg_ready = !busy;
    assign take = cfg.cfg_valid && !busy;
    assign ok   = cfg.cfg_div >= CNT_W'(2);
    assign wrap = (cnt == active_div - ONE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = active_div;
        pend_n    = pend_div;
        tcnt_n    = tick_count;
        applied_n = applied;
        busy_n    = busy;
        err_n     = take && !ok;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (take && ok) begin
                    div_n  = cfg.cfg_div;
                    tcnt_n = '0;
                end
                if (run) state_n = RUN;
            end
            RUN, PEND: begin
                cnt_n = wrap ? '0 : cnt + ONE;
                if (wrap) tcnt_n = tick_count + TONE;
                // applied marks a divisor already swapped in at the accept edge
                if (state == PEND && (applied || wrap || !run)) begin
                    busy_n    = 1'b0;
                    applied_n = 1'b0;
                    state_n   = RUN;
                    if (!applied) begin
                        div_n  = pend_div;
                        tcnt_n = '0;
                    end
                end
                if (take && ok) begin
                    if (wrap || !run) begin
                        div_n     = cfg.cfg_div;
                        tcnt_n    = '0;
                        busy_n    = run;
                        applied_n = run;
                        state_n   = PEND;
                    end else begin
                        pend_n  = cfg.cfg_div;
                        busy_n  = 1'b1;
                        state_n = PEND;
                    end
                end
                if (!run) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            active_div  <= DEF;
            pend_div    <= '0;
            applied     <= 1'b0;
            busy        <= 1'b0;
            cfg.cfg_err <= 1'b0;
            tick        <= 1'b0;
            newClk      <= 1'b0;
            tick_count  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            active_div  <= div_n;
            pend_div    <= pend_n;
            applied     <= applied_n;
            busy        <= busy_n;
            cfg.cfg_err <= err_n;
            tick        <= (state_n != IDLE) && (cnt_n == div_n - ONE);
            newClk      <= (state_n != IDLE) && (cnt_n >= (div_n >> 1));
            tick_count  <= tcnt_n;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed table, corner sequences,
// then random traffic against a period-queue reference model.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        tick, newClk, busy;
    logic [15:0] active_div, tick_count;

    clk_div_ctrl_if #(.CNT_W(16)) cfg ();

    clk_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(4), .TCNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .cfg        (cfg.slave),
        .tick       (tick),
        .newClk     (newClk),
        .active_div (active_div),
        .busy       (busy),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, vld;
        logic [15:0] div;
        logic        tk, nc, bsy, err;
        logic [15:0] adiv, tc;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic r, v, input logic [15:0] d,
                                input logic t, n, b, e,
                                input logic [15:0] a, c);
        vec_t x;
        x.run = r; x.vld = v; x.div = d;
        x.tk = t; x.nc = n; x.bsy = b; x.err = e;
        x.adiv = a; x.tc = c;
        return x;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [15:0] d);
        run = r;
        cfg.cfg_valid = v;
        cfg.cfg_div = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic t, n, b, e,
                       input logic [15:0] a, c);
        logic [36:0] got, exp;
        got = {tick, newClk, busy, cfg.cfg_ready, cfg.cfg_err, active_div, tick_count};
        exp = {t, n, b, !b, e, a, c};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got tk=%b nc=%b bsy=%b rdy=%b err=%b div=%0d tc=%0d, want tk=%b nc=%b bsy=%b rdy=%b err=%b div=%0d tc=%0d",
                     nm, got[36], got[35], got[34], got[33], got[32], got[31:16], got[15:0],
                     t, n, b, !b, e, a, c);
        end
    endtask

    // Reference model: each period is a queue of {tick,newClk} samples
    bit [1:0] q[$];
    bit m_run, m_pend, m_busy, m_once, m_err;
    int m_n, m_pn, m_tc;

    task automatic load(input int nn);
        q.delete();
        for (int i = 0; i < nn; i++)
            q.push_back({bit'(i == nn - 1), bit'(i >= nn / 2)});
    endtask

    task automatic m_reset();
        q.delete();
        m_run = 0; m_pend = 0; m_busy = 0; m_once = 0; m_err = 0;
        m_n = 4; m_pn = 0; m_tc = 0;
    endtask

    task automatic m_step(input bit r, input bit v, input int d);
        bit acc, good, tk;
        acc = v && !m_busy;
        m_err = acc && d < 2;
        good = acc && d >= 2;
        if (!m_run) begin
            if (good) begin m_n = d; m_tc = 0; end
            if (r) begin m_run = 1; load(m_n); end
        end else begin
            tk = q[0][1];
            if (tk) m_tc = (m_tc + 1) & 16'hffff;
            void'(q.pop_front());
            if (m_once) begin m_once = 0; m_busy = 0; end
            if (m_pend && (!r || q.size() == 0)) begin
                m_n = m_pn; m_pend = 0; m_busy = 0; m_tc = 0;
            end
            if (good) begin
                if (!r || q.size() == 0) begin
                    m_n = d; m_tc = 0; m_busy = r; m_once = r;
                end else begin
                    m_pend = 1; m_pn = d; m_busy = 1;
                end
            end
            if (!r) begin m_run = 0; q.delete(); end
            else if (q.size() == 0) load(m_n);
        end
    endtask

    vec_t tbl[23];

    initial begin
        tbl[0]  = mk(1,0,0, 0,0,0,0, 4,0);
        tbl[1]  = mk(1,1,1, 0,0,0,1, 4,0);
        tbl[2]  = mk(1,1,0, 0,1,0,1, 4,0);
        tbl[3]  = mk(1,0,0, 1,1,0,0, 4,0);
        tbl[4]  = mk(1,0,0, 0,0,0,0, 4,1);
        tbl[5]  = mk(1,0,0, 0,0,0,0, 4,1);
        tbl[6]  = mk(1,0,0, 0,1,0,0, 4,1);
        tbl[7]  = mk(1,0,0, 1,1,0,0, 4,1);
        tbl[8]  = mk(1,0,0, 0,0,0,0, 4,2);
        tbl[9]  = mk(1,0,0, 0,0,0,0, 4,2);
        tbl[10] = mk(1,0,0, 0,1,0,0, 4,2);
        tbl[11] = mk(1,0,0, 1,1,0,0, 4,2);
        tbl[12] = mk(1,0,0, 0,0,0,0, 4,3);
        tbl[13] = mk(1,0,0, 0,0,0,0, 4,3);
        tbl[14] = mk(1,1,6, 0,1,1,0, 4,3);
        tbl[15] = mk(1,0,0, 1,1,1,0, 4,3);
        tbl[16] = mk(1,0,0, 0,0,0,0, 6,0);
        tbl[17] = mk(1,0,0, 0,0,0,0, 6,0);
        tbl[18] = mk(1,0,0, 0,0,0,0, 6,0);
        tbl[19] = mk(1,0,0, 0,1,0,0, 6,0);
        tbl[20] = mk(1,0,0, 0,1,0,0, 6,0);
        tbl[21] = mk(1,0,0, 1,1,0,0, 6,0);
        tbl[22] = mk(1,0,0, 0,0,0,0, 6,1);

        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset", 0,0,0,0, 4,0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].run, tbl[i].vld, tbl[i].div);
            chk($sformatf("table[%0d]", i), tbl[i].tk, tbl[i].nc, tbl[i].bsy,
                tbl[i].err, tbl[i].adiv, tbl[i].tc);
        end

        // odd divisor loaded while idle
        cyc(0, 0, 0);
        chk("to_idle", 0,0,0,0, 6,1);
        cyc(0, 1, 5);
        chk("idle_load5", 0,0,0,0, 5,0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("odd5[%0d]", i), (i % 5) == 4, (i % 5) >= 2, 0, 0,
                5, 16'(i / 5));
        end

        // stop with accept on the same edge, then pending 8 dropped into idle
        cyc(0, 1, 4);
        chk("stop_load4", 0,0,0,0, 4,0);
        cyc(1, 0, 0);
        chk("pend_c0", 0,0,0,0, 4,0);
        cyc(1, 1, 8);
        chk("pend_c1", 0,0,1,0, 4,0);
        cyc(1, 0, 0);
        chk("pend_c2", 0,1,1,0, 4,0);
        cyc(0, 0, 0);
        chk("pend_to_idle", 0,0,0,0, 8,0);

        // offer on the tick cycle
        cyc(0, 1, 4);
        chk("reload4", 0,0,0,0, 4,0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("edge_c3", 1,1,0,0, 4,0);
        cyc(1, 1, 3);
        chk("edge_n3_c0", 0,0,1,0, 3,0);
        cyc(1, 0, 0);
        chk("edge_n3_c1", 0,1,0,0, 3,0);
        cyc(1, 0, 0);
        chk("edge_n3_c2", 1,1,0,0, 3,0);
        cyc(1, 0, 0);
        chk("edge_n3_wrap", 0,0,0,0, 3,1);

        // reset while a config is pending
        cyc(1, 1, 7);
        chk("pend7", 0,1,1,0, 3,1);
        reset = 1'b1;
        cyc(1, 0, 0);
        chk("reset_pend", 0,0,0,0, 4,0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("post_reset[%0d]", i), i == 3, i >= 2, 0, 0, 4, 0);
        end

        // random traffic vs model
        begin
            bit r;
            bit v;
            int d;
            reset = 1'b1;
            cyc(0, 0, 0);
            m_reset();
            reset = 1'b0;
            r = 1;
            for (int k = 0; k < 2000; k++) begin
                if ($urandom_range(0, 11) == 0) r = !r;
                v = ($urandom_range(0, 3) == 0);
                d = $urandom_range(0, 9);
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b1;
                    m_reset();
                    cyc(r, v, 16'(d));
                    reset = 1'b0;
                end else begin
                    m_step(r, v, d);
                    cyc(r, v, 16'(d));
                end
                chk($sformatf("rand[%0d]", k),
                    m_run ? q[0][1] : 1'b0, m_run ? q[0][0] : 1'b0,
                    m_busy, m_err, 16'(m_n), 16'(m_tc));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
